// File: rtl/score_bcd_encoder_if.sv
// Bundle of the score converter's request/result signals.
// The master side drives the binary score and the start strobe.
// The slave side is the converter, which returns BUSY, DONE and SCORE.
interface score_bcd_encoder_if #(
  parameter int BIN_W = 10
) ();

  logic [BIN_W-1:0] BIN;    // unsigned binary score
  logic             START;  // conversion request
  logic             BUSY;   // conversion in progress
  logic             DONE;   // one-cycle pulse on SCORE update
  logic [12:0]      SCORE;  // {OVF, HUND, TENS, ONES}

  modport master (
    output BIN,
    output START,
    input  BUSY,
    input  DONE,
    input  SCORE
  );

  modport slave (
    input  BIN,
    input  START,
    output BUSY,
    output DONE,
    output SCORE
  );

endinterface

// File: rtl/score_bcd_encoder.sv
// Sequential binary-to-BCD converter for the seven-segment score display.
// It uses shift-and-add-3 (double dabble) and processes one input bit per clock.
// Inputs above 999 saturate to 999 and set the OVF bit, SCORE[12].
// SCORE is only written on the final iteration, so the display never sees a
// partially converted value.
module score_bcd_encoder #(
  parameter int BIN_W = 10
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  score_bcd_encoder_if.slave bus
);

  localparam int WORK_W = BIN_W + 12;      // 3 BCD nibbles above the binary bits
  localparam int CNT_W  = $clog2(BIN_W);   // holds BIN_W-1

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WORK_W-1:0]  r_work;
  logic [WORK_W-1:0]  w_work_nxt;
  logic [WORK_W-1:0]  w_corr;
  logic [WORK_W-1:0]  w_shifted;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic [12:0]        r_score;
  logic [12:0]        w_score_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_sat;
  logic [BIN_W-1:0]   w_operand;

  // Saturate the incoming score at 999 and flag the overflow.
  always_comb begin
    w_sat     = (bus.BIN > BIN_W'(999));
    w_operand = w_sat ? BIN_W'(999) : bus.BIN;
  end

  // One double-dabble step: all three nibbles are corrected from the same
  // pre-shift values, then the whole working register shifts left by one.
  always_comb begin
    w_corr = r_work;
    for (int k = 0; k < 3; k++) begin
      if (r_work[BIN_W + 4*k +: 4] >= 4'd5) begin
        w_corr[BIN_W + 4*k +: 4] = r_work[BIN_W + 4*k +: 4] + 4'd3;
      end
    end
    w_shifted = w_corr << 1;
  end

  // Next-state logic and datapath updates for the IDLE/CONV controller.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_work_nxt  = r_work;
    w_ovf_nxt   = r_ovf;
    w_score_nxt = r_score;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.START) begin
          w_state_nxt = CONV;
          w_cnt_nxt   = CNT_W'(BIN_W - 1);
          w_work_nxt  = {12'h000, w_operand};
          w_ovf_nxt   = w_sat;
        end
      end
      CONV: begin
        w_work_nxt = w_shifted;
        if (r_cnt == '0) begin
          w_score_nxt = {r_ovf, w_shifted[WORK_W-1 -: 12]};
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in progress.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge.
    if (!RESET_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_ovf   <= 1'b0;
      r_score <= 13'h0000;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_work  <= w_work_nxt;
      r_ovf   <= w_ovf_nxt;
      r_score <= w_score_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.BUSY  = (r_state == CONV);
  assign bus.DONE  = r_done;
  assign bus.SCORE = r_score;

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Directed bench for score_bcd_encoder with the default BIN_W of 10.
// Outputs are sampled 1 ns after each rising edge.
module tb_score_bcd_encoder;

  localparam int BW = 10;

  logic CLOCK_50;
  logic RESET_N;
  int   n_cmp;
  int   n_err;
  logic [12:0] prev_score;

  score_bcd_encoder_if #(.BIN_W(BW)) bus ();

  score_bcd_encoder #(.BIN_W(BW)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus.slave)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference: {ovf, decimal digits of min(v, 999)}.
  function automatic logic [12:0] model(input int v);
    int s;
    s = (v > 999) ? 999 : v;
    model = {logic'(v > 999), 4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Full conversion. SCORE must hold through E1..E9, then update at E10 with DONE.
  task automatic run_conv(input int v);
    logic [12:0] exp;
    exp       = model(v);
    bus.BIN   = BW'(v);
    bus.START = 1'b1;
    tick();                                   // E0
    bus.START = 1'b0;
    bus.BIN   = ~BW'(v);                      // changes during CONV must be ignored
    check("busy_e0", 32'(bus.BUSY), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("score_hold", 32'(bus.SCORE), 32'(prev_score));
      check("done_low", 32'(bus.DONE), 32'd0);
      check("busy_high", 32'(bus.BUSY), 32'd1);
    end
    tick();                                   // E10
    check("score_e10", 32'(bus.SCORE), 32'(exp));
    check("done_e10", 32'(bus.DONE), 32'd1);
    check("busy_e10", 32'(bus.BUSY), 32'd0);
    tick();                                   // E11
    check("done_e11", 32'(bus.DONE), 32'd0);
    check("score_e11", 32'(bus.SCORE), 32'(exp));
    prev_score = exp;
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    n_cmp      = 0;
    n_err      = 0;
    prev_score = 13'h0000;
    RESET_N    = 1'b0;
    bus.START  = 1'b0;
    bus.BIN    = '0;

    // Reset values.
    repeat (2) tick();
    check("rst_score", 32'(bus.SCORE), 32'h0000);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    tick();
    check("idle_score", 32'(bus.SCORE), 32'h0000);
    check("idle_busy", 32'(bus.BUSY), 32'd0);

    // Zero, digit coverage, saturation, and clearing of the ovf bit.
    run_conv(0);
    run_conv(255);
    check("val_255", 32'(prev_score), 32'h0255);
    run_conv(999);
    run_conv(509);
    run_conv(90);
    run_conv(1000);
    check("val_1000", 32'(bus.SCORE), 32'h1999);
    run_conv(1023);
    check("val_1023", 32'(bus.SCORE), 32'h1999);
    run_conv(7);
    check("val_7", 32'(bus.SCORE), 32'h0007);

    // Busy protection: a START at E4 must be ignored.
    bus.BIN   = BW'(123);
    bus.START = 1'b1;
    tick();                                   // E0
    bus.START = 1'b0;
    for (int i = 1; i <= 3; i++) tick();      // E1..E3
    bus.START = 1'b1;
    bus.BIN   = BW'(456);
    tick();                                   // E4
    bus.START = 1'b0;
    bus.BIN   = '0;
    check("bp_busy_e4", 32'(bus.BUSY), 32'd1);
    for (int i = 5; i <= 9; i++) begin
      tick();
      check("bp_done_low", 32'(bus.DONE), 32'd0);
      check("bp_hold", 32'(bus.SCORE), 32'h0007);
    end
    tick();                                   // E10
    check("bp_score", 32'(bus.SCORE), 32'h0123);
    check("bp_done", 32'(bus.DONE), 32'd1);
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      done_cnt += int'(bus.DONE);
      busy_cnt += int'(bus.BUSY);
    end
    check("bp_no_2nd_done", 32'(done_cnt), 32'd0);
    check("bp_no_2nd_busy", 32'(busy_cnt), 32'd0);
    check("bp_final", 32'(bus.SCORE), 32'h0123);

    // Asynchronous reset in the middle of a conversion.
    bus.BIN   = BW'(777);
    bus.START = 1'b1;
    tick();                                   // E0
    bus.START = 1'b0;
    for (int i = 1; i <= 5; i++) tick();      // E5
    RESET_N = 1'b0;
    #1;
    check("mr_score", 32'(bus.SCORE), 32'h0000);
    check("mr_busy", 32'(bus.BUSY), 32'd0);
    check("mr_done", 32'(bus.DONE), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_cnt += int'(bus.DONE);
    end
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      done_cnt += int'(bus.DONE);
      busy_cnt += int'(bus.BUSY);
    end
    check("mr_no_done", 32'(done_cnt), 32'd0);
    check("mr_no_restart", 32'(busy_cnt), 32'd0);
    prev_score = 13'h0000;
    run_conv(42);
    check("val_42", 32'(bus.SCORE), 32'h0042);

    // Back-to-back conversions with START held high, sweeping 0..1023.
    bus.BIN   = '0;
    bus.START = 1'b1;
    for (int v = 0; v < 1024; v++) begin
      tick();                                 // accept edge for v
      bus.BIN = BW'(v + 1);
      check("b2b_busy", 32'(bus.BUSY), 32'd1);
      for (int i = 1; i <= 9; i++) begin
        tick();
        check("b2b_done_low", 32'(bus.DONE), 32'd0);
      end
      tick();                                 // completion edge for v
      check("b2b_done", 32'(bus.DONE), 32'd1);
      check("b2b_score", 32'(bus.SCORE), 32'(model(v)));
    end
    bus.START = 1'b0;
    tick();
    check("b2b_end_done", 32'(bus.DONE), 32'd0);
    check("b2b_end_busy", 32'(bus.BUSY), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
